bk_divider16: RTL and testbench

Sequential 16-bit unsigned restoring divider for the Vedic/Brent-Kung arithmetic datapath. It is the inverse operation to the multiplier path. It produces one quotient bit per clock, and each trial subtraction is computed by a 16-bit Brent-Kung adder used as a subtractor (inverted subtrahend, carry-in 1). A start/busy/done handshake lets a controller issue one division at a time and read the quotient and remainder.

---
 rtl/bk_divider16_pkg.sv | 13 +
 rtl/bk_divider16_sub16.sv | 39 +++
 rtl/bk_divider16.sv | 119 +++++++++++
 tb/tb_bk_divider16.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bk_divider16_pkg.sv
// Shared definitions for the 16-bit Brent-Kung restoring divider.
package bk_divider16_pkg;
   localparam int DIV_W = 16;
   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] LAST_BIT = 5'd15;
   localparam logic [DIV_W-1:0] DIV_ZERO_Q = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;
endpackage

// File: rtl/bk_divider16_sub16.sv
// 16-bit Brent-Kung adder wired as a subtractor: a + ~b + 1.
module bk_sub16
   import bk_divider16_pkg::*;
(
   input  logic [DIV_W-1:0] a,
   input  logic [DIV_W-1:0] b,
   output logic [DIV_W-1:0] diff,
   output logic             no_borrow
);
   logic [DIV_W-1:0] b_n;
   logic [DIV_W-1:0] hp;
   logic [DIV_W-1:0] gg;
   logic [DIV_W-1:0] pp;
   logic [DIV_W:0]   carry;

   always_comb begin
      b_n = ~b;
      hp  = a ^ b_n;
      gg  = a & b_n;
      pp  = hp;
      // Fold the constant carry-in into bit 0 so every prefix includes it.
      gg[0] = gg[0] | pp[0];
      for (int d = 1; d < DIV_W; d = d * 2) begin
         for (int i = 2 * d - 1; i < DIV_W; i = i + 2 * d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
      for (int d = DIV_W / 4; d >= 1; d = d / 2) begin
         for (int i = 3 * d - 1; i < DIV_W; i = i + 2 * d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
      carry     = {gg, 1'b1};
      diff      = hp ^ carry[DIV_W-1:0];
      no_borrow = carry[DIV_W];
   end
endmodule

// File: rtl/bk_divider16.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module bk_divider16
   import bk_divider16_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DIV_W-1:0] quotient,
   output logic [DIV_W-1:0] remainder,
   output logic             div_by_zero
);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] r_q, r_d;
   logic [DIV_W-1:0] q_q, q_d;
   logic [DIV_W-1:0] d_q, d_d;
   logic [DIV_W-1:0] quot_q, quot_d;
   logic [DIV_W-1:0] rem_q, rem_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic [DIV_W-1:0] shifted;
   logic [DIV_W-1:0] trial;
   logic             no_borrow;
   logic             take;

   assign shifted = {r_q[DIV_W-2:0], q_q[DIV_W-1]};

   bk_sub16 u_sub (
      .a         (shifted),
      .b         (d_q),
      .diff      (trial),
      .no_borrow (no_borrow)
   );

   // A set R[15] means the 17-bit shifted remainder already exceeds D.
   assign take = r_q[DIV_W-1] | no_borrow;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      case (state_q)
         RUN: begin
            r_d = take ? trial : shifted;
            q_d = {q_q[DIV_W-2:0], take};
            if (cnt_q == LAST_BIT) begin
               cnt_d   = '0;
               state_d = DONE;
               quot_d  = q_d;
               rem_d   = r_d;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (start) begin
               d_d   = divisor;
               q_d   = dividend;
               r_d   = '0;
               cnt_d = '0;
               if (divisor == '0) begin
                  state_d = DONE;
                  quot_d  = DIV_ZERO_Q;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  dbz_d   = 1'b0;
               end
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_bk_divider16.sv
// Directed and random checks of bk_divider16 against plain / and % arithmetic.
module tb_bk_divider16;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int tests;
   int fails;

   bk_divider16 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present operands with start for one edge, then scramble the operand pins.
   task automatic issue(input logic [15:0] dvd, input logic [15:0] dvs);
      start    = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
   endtask

   // Wait for done after an accepting edge; optionally pulse start at cycle poke.
   task automatic wait_check(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                             input int poke);
      int lat;
      int bcnt;
      logic [15:0] exp_q;
      logic [15:0] exp_r;
      lat  = 0;
      bcnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         if (lat == poke) begin
            start    = 1'b1;
            dividend = 16'd50;
            divisor  = 16'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      if (dvs == 16'd0) begin
         exp_q = 16'hFFFF;
         exp_r = dvd;
      end else begin
         exp_q = dvd / dvs;
         exp_r = dvd % dvs;
      end
      check({tag, ".latency"}, lat, (dvs == 16'd0) ? 0 : 16);
      check({tag, ".busy_cycles"}, bcnt, (dvs == 16'd0) ? 0 : 16);
      check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
      check({tag, ".quotient"}, {16'd0, quotient}, {16'd0, exp_q});
      check({tag, ".remainder"}, {16'd0, remainder}, {16'd0, exp_r});
      check({tag, ".div_by_zero"}, {31'd0, div_by_zero}, {31'd0, (dvs == 16'd0)});
   endtask

   initial begin
      logic [15:0] rd;
      logic [15:0] rs;
      logic        saw_done;
      tests    = 0;
      fails    = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = 16'd0;
      divisor  = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.busy", {31'd0, busy}, 32'd0);
      check("reset.done", {31'd0, done}, 32'd0);
      check("reset.quotient", {16'd0, quotient}, 32'd0);
      check("reset.remainder", {16'd0, remainder}, 32'd0);
      check("reset.dbz", {31'd0, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(16'd100, 16'd7);
      check("d100_7.busy_after_accept", {31'd0, busy}, 32'd1);
      wait_check("d100_7", 16'd100, 16'd7, -1);
      @(posedge clk);
      #1;
      check("d100_7.done_one_cycle", {31'd0, done}, 32'd0);
      check("d100_7.idle_busy", {31'd0, busy}, 32'd0);
      check("d100_7.held_q", {16'd0, quotient}, 32'd14);
      check("d100_7.held_r", {16'd0, remainder}, 32'd2);

      issue(16'hFFFF, 16'h8000);
      wait_check("dffff_8000", 16'hFFFF, 16'h8000, -1);
      issue(16'hFFFF, 16'h0001);
      wait_check("dffff_1", 16'hFFFF, 16'h0001, -1);

      issue(16'd5, 16'd0);
      wait_check("d5_0", 16'd5, 16'd0, -1);
      issue(16'd9, 16'd3);
      wait_check("d9_3", 16'd9, 16'd3, -1);

      issue(16'd1234, 16'd17);
      wait_check("d1234_17_poke", 16'd1234, 16'd17, 8);

      repeat (2) @(posedge clk);
      #1;
      issue(16'd3, 16'hFFFF);
      wait_check("d3_ffff", 16'd3, 16'hFFFF, -1);
      issue(16'd1000, 16'd3);
      wait_check("d1000_3_b2b", 16'd1000, 16'd3, -1);

      issue(16'd1234, 16'd17);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst.busy", {31'd0, busy}, 32'd0);
      check("midrst.done", {31'd0, done}, 32'd0);
      check("midrst.quotient", {16'd0, quotient}, 32'd0);
      check("midrst.remainder", {16'd0, remainder}, 32'd0);
      check("midrst.dbz", {31'd0, div_by_zero}, 32'd0);
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("midrst.no_done", {31'd0, saw_done}, 32'd0);
      issue(16'd40000, 16'd123);
      wait_check("d40000_123", 16'd40000, 16'd123, -1);

      for (int k = 0; k < 24; k++) begin
         rd = 16'($urandom);
         case ($urandom_range(0, 3))
            0: rs = 16'($urandom_range(1, 15));
            1: rs = 16'($urandom);
            2: rs = 16'd0;
            default: rs = 16'($urandom_range(256, 65535));
         endcase
         if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         issue(rd, rs);
         wait_check($sformatf("rand%0d", k), rd, rs, (k % 3 == 0) ? int'($urandom_range(0, 14)) : -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
